// File: rtl/bfloat16_div.sv
// bfloat16_div -- multi-cycle bfloat16 divider, Q = A / B.
//
// A restoring divider produces one quotient bit per cycle from the two
// 8-bit significands. The quotient is then normalised and rounded to
// nearest-even. Special operands (NaN, infinity, zero, subnormals flushed
// to zero) bypass the divider and produce their result directly.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   A, B       bfloat16 dividend / divisor, latched on acceptance
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept operands
//   Q          registered bfloat16 quotient
//   out_valid  Q valid; held until out_ready is sampled high
//   out_ready  consumer accepts Q
//   flags      {invalid, div_by_zero, overflow, underflow}. This port exists
//              only when macro BF16DIV_FLAGS_EN is defined.
//
// Latency, counting the acceptance edge as edge 1: out_valid rises on edge 12
// for normal operands (1 accept + 10 DIVIDE + 1 ROUND) and on edge 1 for
// special cases.
module bfloat16_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Q,
  output logic        out_valid,
  input  logic        out_ready
`ifdef BF16DIV_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_sign;
  logic [7:0]  r_ea, r_eb, r_mb;
  logic [8:0]  r_rem;
  logic [9:0]  r_q;

  // ---- special-case classification of the incoming operands ----
  logic w_sign, w_emax_a, w_emax_b, w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic w_nan, w_inf, w_zero, w_special;
  logic [15:0] w_spec_q;

  assign w_sign   = A[15] ^ B[15];
  assign w_emax_a = &A[14:7];
  assign w_emax_b = &B[14:7];
  assign w_za     = ~|A[14:7];
  assign w_zb     = ~|B[14:7];
  assign w_nan_a  = w_emax_a & (|A[6:0]);
  assign w_nan_b  = w_emax_b & (|B[6:0]);
  assign w_inf_a  = w_emax_a & ~(|A[6:0]);
  assign w_inf_b  = w_emax_b & ~(|B[6:0]);

  // Priority NaN > infinity > zero is built into the masking below.
  assign w_nan     = w_nan_a | w_nan_b | (w_za & w_zb) | (w_inf_a & w_inf_b);
  assign w_inf     = ~w_nan & (w_inf_a | (~w_za & w_zb));
  assign w_zero    = ~w_nan & ~w_inf & (w_za | w_inf_b);
  assign w_special = w_nan | w_inf | w_zero;
  assign w_spec_q  = w_nan ? {w_sign, 8'hFF, 7'h40} :
                     w_inf ? {w_sign, 8'hFF, 7'h00} :
                             {w_sign, 8'h00, 7'h00};

`ifdef BF16DIV_FLAGS_EN
  logic w_dbz;
  assign w_dbz = ~w_za & ~w_emax_a & w_zb;
`endif

  // ---- restoring divide step ----
  // The partial remainder stays below 2*mb, so after a conditional subtract
  // it fits in 8 bits and the left shift never loses a bit.
  logic       w_ge;
  logic [8:0] w_sub, w_rem_sel, w_rem_nx;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_sub     = r_rem - {1'b0, r_mb};
  assign w_rem_sel = w_ge ? w_sub : r_rem;
  assign w_rem_nx  = {w_rem_sel[7:0], 1'b0};

  // ---- normalise and round ----
  logic              w_norm, w_guard, w_sticky, w_inc, w_ovf, w_unf;
  logic [6:0]        w_frac;
  logic [7:0]        w_frac_r;
  logic signed [9:0] w_exp;
  logic [15:0]       w_res;

  assign w_norm   = r_q[9];
  assign w_frac   = w_norm ? r_q[8:2] : r_q[7:1];
  assign w_guard  = w_norm ? r_q[1]   : r_q[0];
  assign w_sticky = (w_norm & r_q[0]) | (r_rem != 9'd0);
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_r = {1'b0, w_frac} + {7'd0, w_inc};
  // A carry out of the fraction bumps the exponent. The low 7 bits are
  // already zero in that case.
  assign w_exp    = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + (w_norm ? 10'sd127 : 10'sd126)
                  + $signed({9'd0, w_frac_r[7]});
  assign w_ovf    = (w_exp >= 10'sd255);
  assign w_unf    = (w_exp <= 10'sd0);
  assign w_res    = w_ovf ? {r_sign, 8'hFF, 7'h00} :
                    w_unf ? {r_sign, 8'h00, 7'h00} :
                            {r_sign, w_exp[7:0], w_frac_r[6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_sign    <= 1'b0;
      r_ea      <= 8'd0;
      r_eb      <= 8'd0;
      r_mb      <= 8'd0;
      r_rem     <= 9'd0;
      r_q       <= 10'd0;
      Q         <= 16'h0000;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef BF16DIV_FLAGS_EN
      flags     <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          r_sign   <= w_sign;
          if (w_special) begin
            Q         <= w_spec_q;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
`ifdef BF16DIV_FLAGS_EN
            flags     <= {w_nan, w_dbz, 2'b00};
`endif
          end else begin
            r_ea    <= A[14:7];
            r_eb    <= B[14:7];
            r_mb    <= {1'b1, B[6:0]};
            r_rem   <= {2'b01, A[6:0]};
            r_q     <= 10'd0;
            r_cnt   <= 4'd0;
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[8:0], w_ge};
          r_rem <= w_rem_nx;
          if (r_cnt == 4'd9) begin
            r_cnt   <= 4'd0;
            r_state <= S_ROUND;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ROUND: begin
          Q         <= w_res;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
`ifdef BF16DIV_FLAGS_EN
          flags     <= {2'b00, w_ovf, w_unf};
`endif
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
